// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of NCH independent integer clock dividers on clk_1.
// Each channel has a runtime-programmable ratio N. The new ratio is held
// pending and is adopted only at a period boundary, on sync, or while the
// channel is disabled, so a period that has started always completes.
// Each channel drives a registered divided clock and one-cycle rise/fall
// strobes that can be used as clock enables.
module clk_div_bank #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter logic [NCH*DW-1:0] DIV_INIT = {8'd128, 8'd32, 8'd4, 8'd2},
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_1,
    input  logic           reset,
    input  logic           sync,
    input  logic [NCH-1:0] ch_en,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    output logic           cfg_err,
    output logic [NCH-1:0] pend,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] ce_rise,
    output logic [NCH-1:0] ce_fall
);

    logic           w_ch_range_ok;
    logic           w_wr_bad;
    logic           w_wr_ok;
    logic [NCH-1:0] w_wr_hit;
    logic           r_err;

    // Write qualification: a ratio below 2 or a nonexistent channel is rejected.
    always_comb begin
        w_ch_range_ok = (int'(cfg_ch) < NCH);
        w_wr_bad      = cfg_we & ((cfg_div < DW'(2)) | ~w_ch_range_ok);
        w_wr_ok       = cfg_we & ~w_wr_bad;
    end

    // Error strobe: one cycle after each rejected write.
    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_wr_bad;
        end
    end

    assign cfg_err = r_err;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DW-1:0] r_cnt;
        logic [DW-1:0] r_div;
        logic [DW-1:0] r_pdiv;
        logic          r_pend;
        logic          r_clk;
        logic          r_rise;
        logic          r_fall;

        logic [DW-1:0] w_half;
        logic [DW-1:0] w_hi_start;
        logic [DW-1:0] w_last;
        logic [DW-1:0] w_cnt_nx;
        logic [DW-1:0] w_new_pdiv;
        logic          w_run;
        logic          w_adopt;

        // Channel next-state: counter wrap at N-1, and when the pending ratio is adopted.
        always_comb begin
            w_hit_default: begin
                w_half     = r_div >> 1;
                w_hi_start = r_div - w_half;
                w_last     = r_div - DW'(1);
            end
            if (r_cnt == w_last) begin
                w_cnt_nx = '0;
            end else begin
                w_cnt_nx = r_cnt + DW'(1);
            end
            w_run   = ch_en[gi] & ~sync;
            w_adopt = ~w_run | (w_cnt_nx == '0);
            if (w_wr_hit[gi]) begin
                w_new_pdiv = cfg_div;
            end else begin
                w_new_pdiv = r_pdiv;
            end
        end

        // Channel state: counter, ratios, divided clock and strobes.
        always_ff @(posedge clk_1 or negedge reset) begin
            if (!reset) begin
                r_cnt  <= '0;
                r_div  <= DIV_INIT[gi*DW +: DW];
                r_pdiv <= DIV_INIT[gi*DW +: DW];
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_pdiv <= w_new_pdiv;
                if (w_adopt) begin
                    r_div  <= w_new_pdiv;
                    r_pend <= 1'b0;
                end else begin
                    r_div  <= r_div;
                    r_pend <= r_pend | w_wr_hit[gi];
                end
                if (w_run) begin
                    r_cnt  <= w_cnt_nx;
                    r_clk  <= (w_cnt_nx >= w_hi_start);
                    r_rise <= (w_cnt_nx == w_hi_start);
                    r_fall <= (w_cnt_nx == '0);
                end else begin
                    r_cnt  <= '0;
                    r_clk  <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end
            end
        end

        assign w_wr_hit[gi] = w_wr_ok & (cfg_ch == CW'(gi));
        assign pend[gi]     = r_pend;
        assign clk_out[gi]  = r_clk;
        assign ce_rise[gi]  = r_rise;
        assign ce_fall[gi]  = r_fall;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank. The reference model builds one
// full output waveform per period from the ratio and plays it out edge by
// edge; ratio changes are applied when a waveform has fully played out.
module tb_clk_div_bank;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 2;
    localparam logic [NCH*DW-1:0] DIV_INIT = {8'd128, 8'd32, 8'd4, 8'd2};

    logic            clk_1 = 1'b0;
    logic            reset;
    logic            sync;
    logic [NCH-1:0]  ch_en;
    logic            cfg_we;
    logic [CW-1:0]   cfg_ch;
    logic [DW-1:0]   cfg_div;
    logic            cfg_err;
    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  ce_rise;
    logic [NCH-1:0]  ce_fall;

    int checks   = 0;
    int failures = 0;

    clk_div_bank #(.NCH(NCH), .DW(DW), .DIV_INIT(DIV_INIT)) dut (
        .clk_1   (clk_1),
        .reset   (reset),
        .sync    (sync),
        .ch_en   (ch_en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_err (cfg_err),
        .pend    (pend),
        .clk_out (clk_out),
        .ce_rise (ce_rise),
        .ce_fall (ce_fall)
    );

    always #5 clk_1 = ~clk_1;

    // reference model state
    int           init_div [NCH] = '{2, 4, 32, 128};
    int           m_div  [NCH];
    int           m_pdiv [NCH];
    int           m_len  [NCH];
    int           m_idx  [NCH];
    bit           m_wave [NCH][256];
    bit [NCH-1:0] m_pend, m_clk, m_rise, m_fall;
    bit           m_err;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c]  = init_div[c];
            m_pdiv[c] = init_div[c];
            m_len[c]  = 0;
            m_idx[c]  = 0;
        end
        m_pend = '0; m_clk = '0; m_rise = '0; m_fall = '0; m_err = 1'b0;
    endfunction

    // One period of N edges: floor(N/2) high cycles that end just before the boundary edge.
    function automatic void load_period(int c);
        int n;
        n = m_div[c];
        for (int k = 0; k < 256; k++) m_wave[c][k] = 1'b0;
        for (int h = 0; h < n / 2; h++) m_wave[c][n - 2 - h] = 1'b1;
        m_len[c] = n;
        m_idx[c] = 0;
    endfunction

    task automatic model_edge();
        bit wr_ok, hit, b;
        wr_ok = cfg_we && (cfg_div >= 8'd2) && (int'(cfg_ch) < NCH);
        m_err = cfg_we && !wr_ok;
        for (int c = 0; c < NCH; c++) begin
            hit = wr_ok && (int'(cfg_ch) == c);
            if (hit) m_pdiv[c] = int'(cfg_div);
            if (sync || !ch_en[c]) begin
                m_div[c] = m_pdiv[c];
                m_pend[c] = 1'b0; m_clk[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
                m_len[c] = 0; m_idx[c] = 0;
            end else begin
                if (m_idx[c] == m_len[c]) load_period(c);
                b = m_wave[c][m_idx[c]];
                m_idx[c]++;
                m_rise[c] = b && !m_clk[c];
                m_clk[c]  = b;
                m_fall[c] = (m_idx[c] == m_len[c]);
                if (m_fall[c]) begin
                    m_div[c]  = m_pdiv[c];
                    m_pend[c] = 1'b0;
                end else if (hit) begin
                    m_pend[c] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [16:0] exp_vec();
        return {m_err, m_pend, m_clk, m_rise, m_fall};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {cfg_err, pend, clk_out, ce_rise, ce_fall};
    endfunction

    task automatic tick();
        @(posedge clk_1);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; sync = 1'b0; ch_en = 4'hF;
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
        model_reset();
        #12;
        checks++;
        if (obs_vec() !== 17'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), 17'd0);
        end
        @(negedge clk_1);
        reset = 1'b1;
    endtask

    task automatic test_free_run();
        int rise_cnt [NCH];
        for (int c = 0; c < NCH; c++) rise_cnt[c] = 0;
        for (int t = 0; t < 256; t++) begin
            tick();
            for (int c = 0; c < NCH; c++) rise_cnt[c] += int'(ce_rise[c]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL free_run cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (rise_cnt[c] !== 256 / init_div[c]) begin
                failures++;
                $display("FAIL free_run_rises ch=%0d got=%0d exp=%0d", c, rise_cnt[c], 256 / init_div[c]);
            end
        end
    endtask

    task automatic test_sync();
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 40)) tick();
            sync = 1'b1;
            tick();
            sync = 1'b0;
            checks++;
            if (clk_out !== 4'h0 || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL sync_clear got=%h exp=%h", obs_vec(), exp_vec());
            end
            for (int t = 0; t < 32; t++) begin
                tick();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL sync_run cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
                end
            end
            checks++;
            if ({ce_fall[1], ce_fall[2]} !== 2'b11) begin
                failures++;
                $display("FAIL sync_align got=%b exp=11", {ce_fall[1], ce_fall[2]});
            end
        end
    endtask

    task automatic test_disable();
        int n;
        n = 0;
        while (clk_out[3] !== 1'b1 && n < 300) begin tick(); n++; end
        checks++;
        if (clk_out[3] !== 1'b1) begin
            failures++;
            $display("FAIL disable_wait_high got=%b exp=1", clk_out[3]);
        end
        ch_en[3] = 1'b0;
        tick();
        checks++;
        if (clk_out[3] !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL disable_drop got=%h exp=%h", obs_vec(), exp_vec());
        end
        repeat (3) tick();
        ch_en[3] = 1'b1;
        n = 0;
        do begin
            tick(); n++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL disable_rerun cyc=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
            end
        end while (ce_rise[3] !== 1'b1 && n < 300);
        checks++;
        if (n !== 64) begin
            failures++;
            $display("FAIL disable_first_rise got=%0d exp=64", n);
        end
    endtask

    task automatic test_ratio_update();
        int highs;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        tick();
        cfg_we = 1'b0;
        checks++;
        if (pend[0] !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL ratio_pend_set got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        checks++;
        if (pend[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL ratio_pend_clear got=%b%b exp=00", pend[0], clk_out[0]);
        end
        highs = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            highs += int'(clk_out[0]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL ratio_run cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (highs !== 4) begin
            failures++;
            $display("FAIL ratio_duty got=%0d exp=4", highs);
        end
    endtask

    task automatic test_cfg_err();
        logic [7:0] bad [2];
        bad[0] = 8'd1; bad[1] = 8'd0;
        for (int k = 0; k < 2; k++) begin
            cfg_we = 1'b1; cfg_ch = 2'($urandom_range(0, 3)); cfg_div = bad[k];
            tick();
            cfg_we = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL cfg_err_pulse div=%0d got=%h exp=%h", bad[k], obs_vec(), exp_vec());
            end
            tick();
            checks++;
            if (cfg_err !== 1'b0 || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL cfg_err_clear got=%h exp=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 1500; t++) begin
            sync = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 99) == 0) ch_en[c] = ~ch_en[c];
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       cfg_div = 8'($urandom_range(0, 1));
                1:       cfg_div = 8'd255;
                default: cfg_div = 8'($urandom_range(2, 12));
            endcase
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
        end
        sync = 1'b0; cfg_we = 1'b0; ch_en = 4'hF;
    endtask

    task automatic test_reset_mid();
        repeat (5) tick();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
        tick();
        cfg_we = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== 17'd0) begin
            failures++;
            $display("FAIL reset_mid_async got=%h exp=%h", obs_vec(), 17'd0);
        end
        #2;
        reset = 1'b1;
        for (int t = 0; t < 300; t++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid_run cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_sync();
        test_disable();
        test_ratio_update();
        test_cfg_err();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
